// File: rtl/ddr3_mcb_ref_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_mcb_ref_sched_pkg
// Description : Shared command encodings, FSM state encoding and timing
//               defaults for the DDR3 MCB refresh scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr3_mcb_ref_sched_pkg;

  // Timing defaults, in controller clocks
  localparam int DEF_CTREFI       = 6240;
  localparam int DEF_CTRP         = 6;
  localparam int DEF_CTRFC        = 88;
  localparam int DEF_MAX_POSTPONE = 8;

  // Width of the owed-refresh counter (holds 0..MAX_POSTPONE)
  localparam int DEBT_W = 4;

  // Refresh-side command encodings toward the PHY command mux
  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_PREA = 2'd1;
  localparam logic [1:0] CMD_REF  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PREA     = 3'd2,
    ST_WAIT_RP  = 3'd3,
    ST_REF      = 3'd4,
    ST_WAIT_RFC = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_mcb_ref_timer.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_mcb_ref_timer
// Description : tREFI interval counter, refresh tick, owed-refresh debt and
//               sticky overflow flag. A low ready clears everything.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_mcb_ref_timer
  import ddr3_mcb_ref_sched_pkg::*;
#(
  parameter int CtREFi       = DEF_CTREFI,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
  input  logic              ddr3_mcb_clk,
  input  logic              ddr3_mcb_rst_n,
  input  logic              ready_i,
  input  logic              ref_issue_i,
  output logic [DEBT_W-1:0] debt_o,
  output logic              ovf_o
);

  localparam logic [15:0]       C_LAST = 16'(CtREFi - 1);
  localparam logic [DEBT_W-1:0] C_MAX  = DEBT_W'(MAX_POSTPONE);

  logic [15:0]       cnt_q,  cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q,  ovf_d;
  logic              w_tick;

  // Interval wrap produces the tick; tick and REF in the same cycle cancel
  always_comb begin
    w_tick = 1'b0;
    cnt_d  = cnt_q;
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (!ready_i) begin
      cnt_d  = '0;
      debt_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (cnt_q == C_LAST) begin
        cnt_d  = '0;
        w_tick = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      if (w_tick && !ref_issue_i) begin
        // Debt is saturated: the owed refresh is lost, flag it
        if (debt_q >= C_MAX) begin
          ovf_d = 1'b1;
        end else begin
          debt_d = debt_q + 1'b1;
        end
      end else if (!w_tick && ref_issue_i && (debt_q != '0)) begin
        debt_d = debt_q - 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign debt_o = debt_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/ddr3_mcb_ref_sched.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_mcb_ref_sched
// Description : DDR3 MCB refresh scheduler and command-bus arbiter. Takes the
//               bus from the user scheduler when refresh is owed and issues
//               PREA (if a bank is open) then REF with tRP/tRFC spacing.
//               CtRP and CtRFC are expected to be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_mcb_ref_sched
  import ddr3_mcb_ref_sched_pkg::*;
#(
  parameter int CtREFi       = DEF_CTREFI,
  parameter int CtRP         = DEF_CTRP,
  parameter int CtRFC        = DEF_CTRFC,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
  input  logic              ddr3_mcb_clk,
  input  logic              ddr3_mcb_rst_n,
  input  logic              i_ready,
  input  logic              user_req,
  input  logic              user_busy,
  input  logic              bank_open,
  output logic              user_gnt,
  output logic              cmd_vld,
  output logic [1:0]        cmd_code,
  output logic [DEBT_W-1:0] ref_debt,
  output logic              ref_done,
  output logic              ref_ovf
);

  localparam int C_WAIT_W = max_int(8, $clog2(max_int(CtRP, CtRFC) + 1));
  // Wait counter holds cycles elapsed since the last command; the wait state
  // is left when the following cycle will be exactly CtRP / CtRFC after it.
  localparam logic [C_WAIT_W-1:0] C_RP_LAST  = C_WAIT_W'(CtRP - 1);
  localparam logic [C_WAIT_W-1:0] C_RFC_LAST = C_WAIT_W'(CtRFC - 1);
  localparam logic [DEBT_W-1:0]   C_MAX      = DEBT_W'(MAX_POSTPONE);

  state_t                state_q, state_d;
  logic [C_WAIT_W-1:0]   wait_q,  wait_d;
  logic                  gnt_q,   gnt_d;
  logic                  vld_q,   vld_d;
  logic [1:0]            code_q,  code_d;
  logic                  done_q,  done_d;
  logic                  w_start;
  logic                  w_ref_issue;
  logic [DEBT_W-1:0]     w_debt;
  logic                  w_ovf;

  assign w_ref_issue = i_ready && (state_q == ST_REF);

  ddr3_mcb_ref_timer #(
    .CtREFi       (CtREFi),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_timer (
    .ddr3_mcb_clk   (ddr3_mcb_clk),
    .ddr3_mcb_rst_n (ddr3_mcb_rst_n),
    .ready_i        (i_ready),
    .ref_issue_i    (w_ref_issue),
    .debt_o         (w_debt),
    .ovf_o          (w_ovf)
  );

  // Next state, wait counter and next registered outputs
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    gnt_d   = 1'b0;
    vld_d   = 1'b0;
    code_d  = CMD_NOP;
    done_d  = 1'b0;
    // Opportunistic when the user is idle, forced once debt saturates
    w_start = ((w_debt != '0) && !user_req) || (w_debt >= C_MAX);
    if (!i_ready) begin
      state_d = ST_IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            state_d = ST_DRAIN;
          end else begin
            gnt_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!user_busy) begin
            state_d = bank_open ? ST_PREA : ST_REF;
          end
        end
        ST_PREA: begin
          state_d = ST_WAIT_RP;
          wait_d  = {{(C_WAIT_W-1){1'b0}}, 1'b1};
        end
        ST_WAIT_RP: begin
          if (wait_q >= C_RP_LAST) begin
            state_d = ST_REF;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_REF: begin
          state_d = ST_WAIT_RFC;
          wait_d  = {{(C_WAIT_W-1){1'b0}}, 1'b1};
        end
        ST_WAIT_RFC: begin
          if (wait_q >= C_RFC_LAST) begin
            state_d = ST_IDLE;
            wait_d  = '0;
            done_d  = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end
      endcase
      // Command outputs follow the state being entered so they are registered
      if (state_d == ST_PREA) begin
        vld_d  = 1'b1;
        code_d = CMD_PREA;
      end else if (state_d == ST_REF) begin
        vld_d  = 1'b1;
        code_d = CMD_REF;
      end
    end
  end

  // State and output registers
  always_ff @(posedge ddr3_mcb_clk or negedge ddr3_mcb_rst_n) begin
    if (!ddr3_mcb_rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      gnt_q   <= 1'b0;
      vld_q   <= 1'b0;
      code_q  <= CMD_NOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign user_gnt = gnt_q;
  assign cmd_vld  = vld_q;
  assign cmd_code = code_q;
  assign ref_done = done_q;
  assign ref_debt = w_debt;
  assign ref_ovf  = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_mcb_ref_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_mcb_ref_sched
// Description : Self-checking bench for ddr3_mcb_ref_sched: directed
//               scenarios plus randomized traffic against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_mcb_ref_sched;

  localparam int CtREFi = 100;
  localparam int CtRP   = 6;
  localparam int CtRFC  = 88;
  localparam int MAXP   = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy   = 1'b0;
  logic       req   = 1'b0;
  logic       busy  = 1'b0;
  logic       bo    = 1'b0;
  logic       gnt, vld, done, ovf;
  logic [1:0] code;
  logic [3:0] debt;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since ready, owed refreshes, and a refresh pass
  // seen as idle / draining / a command timeline indexed by m_k
  int   m_n    = 0;
  int   m_debt = 0;
  int   m_mode = 0;   // 0 idle, 1 draining, 2 command timeline
  int   m_k    = 0;
  bit   m_pre  = 1'b0;
  bit   m_ovf  = 1'b0;
  logic e_gnt  = 1'b0;
  logic e_vld  = 1'b0;
  logic e_done = 1'b0;
  logic [1:0] e_code = 2'd0;

  ddr3_mcb_ref_sched #(
    .CtREFi       (CtREFi),
    .CtRP         (CtRP),
    .CtRFC        (CtRFC),
    .MAX_POSTPONE (MAXP)
  ) dut (
    .ddr3_mcb_clk   (clk),
    .ddr3_mcb_rst_n (rst_n),
    .i_ready        (rdy),
    .user_req       (req),
    .user_busy      (busy),
    .bank_open      (bo),
    .user_gnt       (gnt),
    .cmd_vld        (vld),
    .cmd_code       (code),
    .ref_debt       (debt),
    .ref_done       (done),
    .ref_ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, got, exp, m_n);
    end
  endtask

  // Advance the model by one clock using the inputs seen at this edge
  task automatic model_step();
    bit tick, refnow, start, last;
    int ref_k;
    if (!rst_n || !rdy) begin
      m_n = 0; m_debt = 0; m_ovf = 1'b0; m_mode = 0; m_k = 0; m_pre = 1'b0;
      e_gnt = 1'b0; e_vld = 1'b0; e_code = 2'd0; e_done = 1'b0;
      return;
    end
    ref_k  = m_pre ? CtRP : 0;
    m_n++;
    tick   = ((m_n % CtREFi) == 0);
    refnow = (m_mode == 2) && (m_k == ref_k);
    start  = (m_mode == 0) && (((m_debt > 0) && !req) || (m_debt >= MAXP));
    last   = (m_mode == 2) && (m_k == ref_k + CtRFC - 1);
    e_gnt  = (m_mode == 0) && !start;
    e_done = last;
    if (tick && !refnow) begin
      if (m_debt == MAXP) m_ovf = 1'b1;
      else m_debt++;
    end else if (refnow && !tick) begin
      m_debt--;
    end
    case (m_mode)
      0: if (start) m_mode = 1;
      1: if (!busy) begin m_mode = 2; m_k = 0; m_pre = bo; end
      default: if (last) m_mode = 0; else m_k++;
    endcase
    ref_k  = m_pre ? CtRP : 0;
    e_vld  = (m_mode == 2) && ((m_k == 0) || (m_k == ref_k));
    e_code = !e_vld ? 2'd0 : ((m_k == ref_k) ? 2'd2 : 2'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("user_gnt", 16'(gnt),  16'(e_gnt));
    chk("cmd_vld",  16'(vld),  16'(e_vld));
    chk("cmd_code", 16'(code), 16'(e_code));
    chk("ref_debt", 16'(debt), 16'(m_debt));
    chk("ref_done", 16'(done), 16'(e_done));
    chk("ref_ovf",  16'(ovf),  16'(m_ovf));
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 2000 && m_n != target; i++) cycle();
    if (m_n != target) begin
      total++;
      bad++;
      $error("FAIL run_until: observed n=%0d expected n=%0d", m_n, target);
    end
  endtask

  initial begin
    // Reset
    repeat (3) cycle();
    chk("rst_gnt",  16'(gnt),  16'd0);
    chk("rst_vld",  16'(vld),  16'd0);
    chk("rst_code", 16'(code), 16'd0);
    chk("rst_debt", 16'(debt), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_ovf",  16'(ovf),  16'd0);
    rst_n = 1'b1;
    repeat (2) cycle();
    rdy = 1'b1;

    // Idle bus, no open bank: tick 100, REF 102, done 190
    run_until(99);  chk("s1_debt_pre", 16'(debt), 16'd0);
    run_until(100); chk("s1_debt_tick", 16'(debt), 16'd1);
    run_until(102); chk("s1_ref_code", 16'(code), 16'd2);
                    chk("s1_ref_vld",  16'(vld),  16'd1);
    run_until(190); chk("s1_done", 16'(done), 16'd1);
                    chk("s1_gnt_low", 16'(gnt), 16'd0);
    run_until(191); chk("s1_gnt_back", 16'(gnt), 16'd1);
                    chk("s1_debt_zero", 16'(debt), 16'd0);

    // Bank open: PREA 202, REF 208, grant back at 297
    bo = 1'b1;
    run_until(202); chk("s2_prea", 16'(code), 16'd1);
    run_until(208); chk("s2_ref", 16'(code), 16'd2);
    run_until(296); chk("s2_gnt_low", 16'(gnt), 16'd0);
    run_until(297); chk("s2_gnt_back", 16'(gnt), 16'd1);

    // Continuous user traffic: debt climbs to 8, then forced refresh
    req = 1'b1;
    run_until(1000); chk("s3_debt8", 16'(debt), 16'd8);
    run_until(1001); chk("s3_gnt_drop", 16'(gnt), 16'd0);
    run_until(1008); chk("s3_ref", 16'(code), 16'd2);
    run_until(1009); chk("s3_debt7", 16'(debt), 16'd7);

    // Refresh blocked by a busy user: overflow, then PREA after busy falls
    rdy = 1'b0; repeat (2) cycle(); rdy = 1'b1;
    busy = 1'b1;
    run_until(900); chk("s4_ovf", 16'(ovf), 16'd1);
                    chk("s4_debt", 16'(debt), 16'd8);
    run_until(903); chk("s4_no_cmd", 16'(vld), 16'd0);
    busy = 1'b0;
    run_until(904); chk("s4_prea", 16'(code), 16'd1);
    run_until(911); chk("s4_debt7", 16'(debt), 16'd7);
    run_until(1000); chk("s4_ovf_sticky", 16'(ovf), 16'd1);

    // REF coincident with a tick at debt 3 leaves debt at 3
    rdy = 1'b0; repeat (2) cycle(); rdy = 1'b1;
    bo = 1'b0; req = 1'b1;
    run_until(397); req = 1'b0;
    run_until(399); chk("s5_ref", 16'(code), 16'd2);
    run_until(400); chk("s5_debt3", 16'(debt), 16'd3);

    // Ready dropped during tRFC wait clears everything
    run_until(420);
    rdy = 1'b0;
    cycle();
    chk("s6_debt", 16'(debt), 16'd0);
    chk("s6_gnt",  16'(gnt),  16'd0);
    chk("s6_vld",  16'(vld),  16'd0);
    rdy = 1'b1;
    run_until(99);  chk("s6_no_tick", 16'(debt), 16'd0);
    run_until(100); chk("s6_tick", 16'(debt), 16'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rdy  = ($urandom_range(0, 399) != 0);
      req  = ($urandom_range(0, 3) != 0);
      busy = ($urandom_range(0, 2) == 0);
      bo   = $urandom_range(0, 1) != 0;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
